// File: rtl/clock_gen_sequencer.sv
// Control-plane sequencer for the clock generation datapath: validates and shadows
// the requested config, derives compare thresholds and sequences the generator.
module clock_gen_sequencer #(
  parameter int COUNTER_WIDTH  = 16,
  parameter int PREEMPT_CYCLES = 8,
  parameter int VIOL_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [COUNTER_WIDTH-1:0] cfg_half_rate_i,
  input  logic                     cfg_polarity_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  output logic                     error_o,
  output logic                     running_o,
  output logic [2:0]               state_o,
  output logic                     set_polarity_o,
  output logic                     starting_polarity_o,
  output logic                     generation_en_o,
  input  logic                     busy_i,
  output logic [COUNTER_WIDTH-1:0] expected_half_rate_minus_two_o,
  output logic [COUNTER_WIDTH-1:0] expected_quarter_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0] preemptive_half_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0] preemptive_quarter_rate_minus_one_o,
  input  logic                     pause_start_violation_i,
  input  logic                     pause_stop_violation_i,
  output logic [VIOL_WIDTH-1:0]    violation_count_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3
  } state_e;

  localparam logic [COUNTER_WIDTH-1:0] MIN_HALF = COUNTER_WIDTH'(2 * PREEMPT_CYCLES + 2);
  localparam logic [COUNTER_WIDTH-1:0] PREEMPT  = COUNTER_WIDTH'(PREEMPT_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] TWO      = COUNTER_WIDTH'(2);

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] half_q, half_d;
  logic                     pol_q, pol_d;
  logic                     loaded_q, loaded_d;
  logic                     pending_q, pending_d;
  logic                     drain_seen_q, drain_seen_d;
  logic                     error_q, error_d;
  logic                     start_pol_q, start_pol_d;
  logic [COUNTER_WIDTH-1:0] exp_half_q, exp_half_d;
  logic [COUNTER_WIDTH-1:0] exp_quarter_q, exp_quarter_d;
  logic [COUNTER_WIDTH-1:0] pre_half_q, pre_half_d;
  logic [COUNTER_WIDTH-1:0] pre_quarter_q, pre_quarter_d;
  logic [VIOL_WIDTH-1:0]    viol_q, viol_d;

  logic                     cfg_hs;
  logic                     cfg_legal;
  logic [COUNTER_WIDTH-1:0] quarter;
  logic [1:0]               viol_inc;
  logic [VIOL_WIDTH:0]      viol_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      half_q        <= '0;
      pol_q         <= 1'b0;
      loaded_q      <= 1'b0;
      pending_q     <= 1'b0;
      drain_seen_q  <= 1'b0;
      error_q       <= 1'b0;
      start_pol_q   <= 1'b0;
      exp_half_q    <= '0;
      exp_quarter_q <= '0;
      pre_half_q    <= '0;
      pre_quarter_q <= '0;
      viol_q        <= '0;
    end else if (clk_en_i) begin
      state_q       <= state_d;
      half_q        <= half_d;
      pol_q         <= pol_d;
      loaded_q      <= loaded_d;
      pending_q     <= pending_d;
      drain_seen_q  <= drain_seen_d;
      error_q       <= error_d;
      start_pol_q   <= start_pol_d;
      exp_half_q    <= exp_half_d;
      exp_quarter_q <= exp_quarter_d;
      pre_half_q    <= pre_half_d;
      pre_quarter_q <= pre_quarter_d;
      viol_q        <= viol_d;
    end else begin
      error_q       <= 1'b0;
    end
  end

  always_comb begin
    cfg_ready_o = (state_q == IDLE) || ((state_q == RUN) && !pending_q);
    cfg_hs      = cfg_valid_i && cfg_ready_o && clk_en_i;
    cfg_legal   = (cfg_half_rate_i >= MIN_HALF);

    state_d      = state_q;
    half_d       = half_q;
    pol_d        = pol_q;
    loaded_d     = loaded_q;
    pending_d    = pending_q;
    error_d      = 1'b0;
    drain_seen_d = (state_q == DRAIN);

    if (cfg_hs && cfg_legal) begin
      half_d   = cfg_half_rate_i;
      pol_d    = cfg_polarity_i;
      loaded_d = 1'b1;
    end
    if (cfg_hs && !cfg_legal) begin
      error_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          if (loaded_q) state_d = LOAD;
          else          error_d = 1'b1;
        end
      end
      LOAD: begin
        pending_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        // A config landing in RUN leaves immediately so the generator stops one cycle later.
        if (stop_i) begin
          state_d   = DRAIN;
          pending_d = 1'b0;
        end else if (pending_q || (cfg_hs && cfg_legal)) begin
          state_d   = DRAIN;
          pending_d = 1'b1;
        end
      end
      DRAIN: begin
        if (start_i) pending_d = 1'b1;
        // busy_i lags enable by a cycle, so the first DRAIN cycle never looks at it.
        if (drain_seen_q && !busy_i) begin
          state_d = pending_d ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    quarter       = half_q >> 1;
    start_pol_d   = start_pol_q;
    exp_half_d    = exp_half_q;
    exp_quarter_d = exp_quarter_q;
    pre_half_d    = pre_half_q;
    pre_quarter_d = pre_quarter_q;
    if (state_q == LOAD) begin
      start_pol_d   = pol_q;
      exp_half_d    = half_q - TWO;
      exp_quarter_d = quarter - ONE;
      pre_half_d    = half_q - PREEMPT - ONE;
      pre_quarter_d = quarter - PREEMPT - ONE;
    end

    viol_inc = {1'b0, pause_start_violation_i} + {1'b0, pause_stop_violation_i};
    viol_sum = {1'b0, viol_q} + {{(VIOL_WIDTH - 1){1'b0}}, viol_inc};
    viol_d   = viol_sum[VIOL_WIDTH] ? '1 : viol_sum[VIOL_WIDTH-1:0];
  end

  always_comb begin
    state_o                             = state_q;
    running_o                           = (state_q == RUN);
    generation_en_o                     = (state_q == RUN);
    set_polarity_o                      = (state_q == LOAD) && clk_en_i;
    error_o                             = error_q;
    starting_polarity_o                 = start_pol_q;
    expected_half_rate_minus_two_o      = exp_half_q;
    expected_quarter_rate_minus_one_o   = exp_quarter_q;
    preemptive_half_rate_minus_one_o    = pre_half_q;
    preemptive_quarter_rate_minus_one_o = pre_quarter_q;
    violation_count_o                   = viol_q;
  end

endmodule

// File: doc/clock_gen_sequencer.md
Name: clock_gen_sequencer

Overview:
- Control-plane sequencer for the clock generation datapath. It accepts a requested half-period and a starting polarity, validates them, and derives the four compare thresholds (expected and preemptive, half and quarter).
- It sequences polarity preset, enable, graceful stop and live reconfiguration of the generator.
- It counts pause-phase violations reported by the generator.
- It sits between the register/host interface and the generation block.

Parameters:
- COUNTER_WIDTH, 16, width of all cycle thresholds; equals clks_alot_p::COUNTER_WIDTH.
- PREEMPT_CYCLES, 8, preemptive anticipation in sys cycles.
- VIOL_WIDTH, 8, width of the saturating violation counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en_i  in  1  domain clock enable; all state holds while low.
- cfg_valid_i  in  1  config request valid.
- cfg_ready_o  out  1  config can be accepted.
- cfg_half_rate_i  in  COUNTER_WIDTH  requested half-period in sys cycles.
- cfg_polarity_i  in  1  requested starting polarity.
- start_i  in  1  start pulse.
- stop_i  in  1  stop pulse.
- error_o  out  1  one-cycle pulse on rejected config or on start with no config.
- running_o  out  1  high in RUN.
- state_o  out  3  FSM state encoding: IDLE=0, LOAD=1, RUN=2, DRAIN=3.
- set_polarity_o  out  1  polarity preset strobe to the generator.
- starting_polarity_o  out  1  committed polarity.
- generation_en_o  out  1  generator enable.
- busy_i  in  1  generator busy.
- expected_half_rate_minus_two_o  out  COUNTER_WIDTH  committed threshold.
- expected_quarter_rate_minus_one_o  out  COUNTER_WIDTH  committed threshold.
- preemptive_half_rate_minus_one_o  out  COUNTER_WIDTH  committed threshold.
- preemptive_quarter_rate_minus_one_o  out  COUNTER_WIDTH  committed threshold.
- pause_start_violation_i  in  1  from the generator.
- pause_stop_violation_i  in  1  from the generator.
- violation_count_o  out  VIOL_WIDTH  saturating count of violations.

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - All outputs go to 0 and the FSM goes to IDLE.
  - The shadow config, the cfg_loaded flag and the reconfig_pending flag clear.
- clk_en_i low: no state change, no pulses, no counting; stimulus on input pulses during this time is lost.
- Config validation:
  - MIN_HALF = 2*PREEMPT_CYCLES+2. A config is legal iff cfg_half_rate_i >= MIN_HALF.
  - cfg_ready_o = 1 in IDLE, and in RUN when reconfig_pending = 0; 0 otherwise.
  - Handshake fires when cfg_valid_i && cfg_ready_o && clk_en_i.
  - Illegal config: error_o pulses the next cycle; shadow config and flags are unchanged.
  - Legal config: the shadow register captures half-rate H and polarity P; cfg_loaded is set.
  - A legal config accepted in RUN also sets reconfig_pending.
- Derivation, registered from the shadow register:
  - Q = H>>1.
  - exp_half = H-2.
  - exp_quarter = Q-1.
  - pre_half = H-PREEMPT_CYCLES-1.
  - pre_quarter = Q-PREEMPT_CYCLES-1.
  - All arithmetic is unsigned at COUNTER_WIDTH. Underflow is impossible given MIN_HALF.
- Threshold outputs and starting_polarity_o update only in the LOAD state and are stable at all other times.
- FSM:
  - IDLE:
    - start_i && cfg_loaded → LOAD.
    - start_i && !cfg_loaded → error_o pulse, stay in IDLE.
    - start_i && stop_i in the same cycle: stop wins and start is ignored.
  - LOAD (exactly 1 cycle):
    - Commit thresholds and polarity.
    - set_polarity_o = 1 for this cycle only; generation_en_o = 0.
    - Clear reconfig_pending → RUN.
  - RUN:
    - generation_en_o = 1.
    - stop_i → DRAIN and clear reconfig_pending (the stop takes priority over the reconfig; the config stays loaded).
    - Otherwise, if reconfig_pending → DRAIN.
    - A config accepted in the same cycle as stop_i is stored with reconfig_pending = 0.
  - DRAIN:
    - generation_en_o = 0.
    - Wait for busy_i = 0, sampled no earlier than the second DRAIN cycle. This covers the generator's 1-cycle busy delay.
    - Then: reconfig_pending → LOAD; else → IDLE.
    - start_i during DRAIN sets reconfig_pending (restart).
- Latency:
  - start_i to generation_en_o = 2 cycles (IDLE→LOAD→RUN).
  - Config accepted in RUN to generation_en_o falling = 1 cycle.
- Violation counter:
  - Increments by 1 per cycle with either violation input high; increments by 2 when both are high.
  - Saturates at all-ones and clears only on reset.
- running_o = (state == RUN).

Test Plan:
1. Legal config and start:
   - Stimulus: COUNTER_WIDTH=16, PREEMPT=8; cfg H=40, P=1; then start_i.
   - Response: the LOAD cycle has set_polarity_o=1; outputs read 38/19/31/11 and starting_polarity_o=1; generation_en_o=1 two cycles after start_i.
2. Illegal config:
   - Stimulus: cfg H=17.
   - Response: error_o pulses once; cfg_loaded remains 0; a following start_i gives another error_o and the FSM stays in IDLE.
3. Live reconfiguration:
   - Stimulus: in RUN at H=40, send cfg H=100; hold busy_i=1 for 5 cycles after generation_en_o falls.
   - Response: DRAIN lasts until busy_i=0; LOAD follows; outputs become 98/49/91/41; RUN resumes.
4. Stop wins over pending reconfig:
   - Stimulus: stop_i and a legal cfg H=60 in the same RUN cycle.
   - Response: DRAIN then IDLE; thresholds unchanged at 38/19/31/11; a later start loads 58/29/51/21.
5. Asynchronous reset mid-RUN:
   - Stimulus: rst_n low asynchronously while in RUN.
   - Response: generation_en_o and all thresholds are 0 immediately; state_o=0.
6. Violation counter saturation:
   - Stimulus: VIOL_WIDTH=8; hold both violation inputs high for 130 cycles.
   - Response: violation_count_o saturates at 255. With clk_en_i low for 10 of those cycles, the count is 240.
